// File: rtl/tile_map_scheduler.sv
// Rebuilds the double-buffered tile bitmap once per frame tick: clear, power-up, foods, snake, then flip banks.
// One tile RAM write per clock; all outputs registered and aligned with the state they belong to.
module tile_map_scheduler #(
  parameter int unsigned GRID_W    = 32,
  parameter int unsigned GRID_H    = 24,
  parameter int unsigned CW        = 5,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned LOG_LEN   = 5,
  parameter int unsigned MAX_FOODS = 4,
  parameter int unsigned LOG_FOODS = 3,
  parameter int unsigned AW        = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic [MAX_LEN*CW-1:0]   snake_x,
  input  logic [MAX_LEN*CW-1:0]   snake_y,
  input  logic [LOG_LEN-1:0]      len,
  input  logic [MAX_FOODS*CW-1:0] food_x,
  input  logic [MAX_FOODS*CW-1:0] food_y,
  input  logic [LOG_FOODS-1:0]    num_foods,
  input  logic                    pu_valid,
  input  logic                    pu_fast,
  input  logic [CW-1:0]           pu_x,
  input  logic [CW-1:0]           pu_y,
  output logic                    wr_en,
  output logic                    wr_bank,
  output logic [AW-1:0]           wr_addr,
  output logic [2:0]              wr_data,
  output logic                    disp_bank,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int unsigned NTILES = GRID_W * GRID_H;
  localparam int unsigned SIW    = $clog2(MAX_LEN);
  localparam int unsigned FIW    = $clog2(MAX_FOODS);

  typedef enum logic [2:0] {IDLE, CLEAR, PU, FOOD, SNAKE, DONE} state_t;

  state_t                  state, state_n;
  logic [AW-1:0]           cnt, cnt_n;
  logic                    start;
  logic                    pending;
  logic [MAX_LEN*CW-1:0]   snake_x_l, snake_y_l;
  logic [MAX_FOODS*CW-1:0] food_x_l, food_y_l;
  logic [LOG_LEN-1:0]      len_l;
  logic [LOG_FOODS-1:0]    nf_l;
  logic                    pu_valid_l, pu_fast_l;
  logic [CW-1:0]           pu_x_l, pu_y_l;

  logic                    wr_en_n;
  logic [AW-1:0]           wr_addr_n;
  logic [2:0]              wr_data_n;
  logic [CW-1:0]           sel_x, sel_y;

  // Next state, entry index, and the write that belongs to the entered state.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    start     = frame_tick | pending;
    wr_en_n   = 1'b0;
    wr_addr_n = '0;
    wr_data_n = 3'd0;
    sel_x     = '0;
    sel_y     = '0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
      CLEAR: begin
        if (32'(cnt) == NTILES - 1) begin
          state_n = PU;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      PU: begin
        cnt_n = '0;
        if (nf_l != '0)       state_n = FOOD;
        else if (len_l != '0) state_n = SNAKE;
        else                  state_n = DONE;
      end
      FOOD: begin
        if (32'(cnt) + 1 >= 32'(nf_l)) begin
          cnt_n   = '0;
          state_n = (len_l != '0) ? SNAKE : DONE;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      SNAKE: begin
        if (32'(cnt) + 1 >= 32'(len_l)) begin
          cnt_n   = '0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    case (state_n)
      CLEAR: begin
        wr_en_n   = 1'b1;
        wr_addr_n = cnt_n;
      end
      PU: begin
        sel_x     = pu_x_l;
        sel_y     = pu_y_l;
        wr_en_n   = pu_valid_l;
        wr_data_n = pu_fast_l ? 3'd4 : 3'd3;
      end
      FOOD: begin
        sel_x     = food_x_l[int'(cnt_n[FIW-1:0]) * CW +: CW];
        sel_y     = food_y_l[int'(cnt_n[FIW-1:0]) * CW +: CW];
        wr_en_n   = 1'b1;
        wr_data_n = 3'd2;
      end
      SNAKE: begin
        sel_x     = snake_x_l[int'(cnt_n[SIW-1:0]) * CW +: CW];
        sel_y     = snake_y_l[int'(cnt_n[SIW-1:0]) * CW +: CW];
        wr_en_n   = 1'b1;
        wr_data_n = 3'd1;
      end
      default: ;
    endcase

    // Off-grid entries keep their cycle but never reach the RAM.
    if (state_n == PU || state_n == FOOD || state_n == SNAKE) begin
      wr_en_n   = wr_en_n && (32'(sel_x) < GRID_W) && (32'(sel_y) < GRID_H);
      wr_addr_n = AW'(32'(sel_y) * GRID_W + 32'(sel_x));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 3'd0;
      wr_bank    <= 1'b1;
      disp_bank  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      pending    <= 1'b0;
      snake_x_l  <= '0;
      snake_y_l  <= '0;
      food_x_l   <= '0;
      food_y_l   <= '0;
      len_l      <= '0;
      nf_l       <= '0;
      pu_valid_l <= 1'b0;
      pu_fast_l  <= 1'b0;
      pu_x_l     <= '0;
      pu_y_l     <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      busy    <= (state_n != IDLE);
      done    <= (state_n == DONE);

      if (state == DONE) begin
        disp_bank <= ~disp_bank;
        wr_bank   <= disp_bank;
      end

      // Snapshot on start; ticks arriving while busy queue one rebuild, further ones are lost.
      if (state == IDLE) begin
        if (start) begin
          snake_x_l  <= snake_x;
          snake_y_l  <= snake_y;
          food_x_l   <= food_x;
          food_y_l   <= food_y;
          len_l      <= (32'(len) > MAX_LEN) ? LOG_LEN'(MAX_LEN) : len;
          nf_l       <= (32'(num_foods) > MAX_FOODS) ? LOG_FOODS'(MAX_FOODS) : num_foods;
          pu_valid_l <= pu_valid;
          pu_fast_l  <= pu_fast;
          pu_x_l     <= pu_x;
          pu_y_l     <= pu_y;
          pending    <= 1'b0;
          if (frame_tick && pending) overrun <= 1'b1;
        end
      end else if (frame_tick) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tile_map_scheduler.sv
// Directed bench for tile_map_scheduler: per-cycle comparison against a frame-level write-list model
// plus literal checks on counts, tile contents, banks and overrun.
module tb_tile_map_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic [79:0] snake_x, snake_y;
  logic [4:0]  len;
  logic [19:0] food_x, food_y;
  logic [2:0]  num_foods;
  logic        pu_valid, pu_fast;
  logic [4:0]  pu_x, pu_y;
  logic        wr_en, wr_bank, disp_bank, busy, done, overrun;
  logic [9:0]  wr_addr;
  logic [2:0]  wr_data;

  tile_map_scheduler dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .snake_x(snake_x), .snake_y(snake_y), .len(len),
    .food_x(food_x), .food_y(food_y), .num_foods(num_foods),
    .pu_valid(pu_valid), .pu_fast(pu_fast), .pu_x(pu_x), .pu_y(pu_y),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .disp_bank(disp_bank), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [9:0] addr;
    logic [2:0] data;
    logic       done;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         sx[16], sy[16], fx[4], fy[4];
  int         len_v, nf_v, pux, puy;
  logic       puv, puf;
  logic [2:0] ram [2][1024];
  logic [2:0] hist[$];
  int         busy_cyc, done_cnt, clr_w, pu_w, food_w, snake_w, gap, gap_max;
  logic       exp_disp = 1'b0;
  logic       run = 1'b0;
  logic       ok;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 16; i++) begin
      snake_x[i*5 +: 5] = 5'(sx[i]);
      snake_y[i*5 +: 5] = 5'(sy[i]);
    end
    for (int i = 0; i < 4; i++) begin
      food_x[i*5 +: 5] = 5'(fx[i]);
      food_y[i*5 +: 5] = 5'(fy[i]);
    end
    len       = 5'(len_v);
    num_foods = 3'(nf_v);
    pu_valid  = puv;
    pu_fast   = puf;
    pu_x      = 5'(pux);
    pu_y      = 5'(puy);
  endtask

  task automatic push_entry(input logic en, input int x, input int y, input logic [2:0] code);
    exp_t n;
    n.en   = en && (x < 32) && (y < 24);
    n.addr = 10'(y * 32 + x);
    n.data = code;
    n.done = 1'b0;
    exp_q.push_back(n);
  endtask

  // Expected per-cycle write list of one rebuild, from the current bench inputs.
  task automatic model_build();
    exp_t n;
    int ln, nf;
    for (int a = 0; a < 768; a++) push_entry(1'b1, a % 32, a / 32, 3'd0);
    push_entry(puv, pux, puy, puf ? 3'd4 : 3'd3);
    nf = (nf_v > 4) ? 4 : nf_v;
    ln = (len_v > 16) ? 16 : len_v;
    for (int i = 0; i < nf; i++) push_entry(1'b1, fx[i], fy[i], 3'd2);
    for (int i = 0; i < ln; i++) push_entry(1'b1, sx[i], sy[i], 3'd1);
    n.en = 1'b0; n.addr = '0; n.data = '0; n.done = 1'b1;
    exp_q.push_back(n);
  endtask

  task automatic reset_stats();
    busy_cyc = 0; done_cnt = 0; clr_w = 0; pu_w = 0; food_w = 0; snake_w = 0;
    gap = 0; gap_max = 0;
    hist.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!busy && exp_q.size() == 0) break;
    end
    if (i == budget) chk("wait_idle_timeout", 1, 0);
  endtask

  // Per-cycle compare against the model's write list; also builds a shadow RAM.
  always @(negedge clk) begin
    if (run && !rst) begin
      chk("disp_bank", int'(disp_bank), int'(exp_disp));
      chk("wr_bank", int'(wr_bank), int'(!exp_disp));
      if (busy) begin
        busy_cyc++;
        gap = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_busy", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          ok = (wr_en === e.en) && (done === e.done) &&
               (!e.en || (wr_addr === e.addr && wr_data === e.data));
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL cycle_out: got en=%0b addr=%0d data=%0d done=%0b expected en=%0b addr=%0d data=%0d done=%0b",
                     wr_en, wr_addr, wr_data, done, e.en, e.addr, e.data, e.done);
          end
          if (e.done) exp_disp = !exp_disp;
        end
        if (wr_en) begin
          ram[wr_bank][wr_addr] = wr_data;
          case (wr_data)
            3'd0: clr_w++;
            3'd1: snake_w++;
            3'd2: food_w++;
            default: pu_w++;
          endcase
          if (wr_addr == 10'd165 && wr_data != 3'd0) hist.push_back(wr_data);
        end
        if (done) done_cnt++;
      end else begin
        chk("idle_quiet", int'({wr_en, done}), 0);
        if (exp_q.size() != 0) begin
          gap++;
          if (gap > gap_max) gap_max = gap;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin sx[i] = 0; sy[i] = 0; end
    for (int i = 0; i < 4; i++) begin fx[i] = 0; fy[i] = 0; end
    len_v = 0; nf_v = 0; puv = 0; puf = 0; pux = 0; puy = 0;
    apply();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_disp", int'(disp_bank), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    run = 1'b1;

    // Basic frame: 3-segment snake, one food, fast power-up at origin.
    len_v = 3; sx[0] = 5; sy[0] = 5; sx[1] = 4; sy[1] = 5; sx[2] = 3; sy[2] = 5;
    nf_v = 1; fx[0] = 10; fy[0] = 7;
    puv = 1; puf = 1; pux = 0; puy = 0;
    apply(); model_build(); reset_stats(); tick(); wait_idle(2000);
    chk("t1_busy_cycles", busy_cyc, 774);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_clears", clr_w, 768);
    chk("t1_pu_writes", pu_w, 1);
    chk("t1_food_writes", food_w, 1);
    chk("t1_snake_writes", snake_w, 3);
    chk("t1_tile0", int'(ram[1][0]), 4);
    chk("t1_tile234", int'(ram[1][234]), 2);
    chk("t1_tile165", int'(ram[1][165]), 1);
    chk("t1_tile164", int'(ram[1][164]), 1);
    chk("t1_tile163", int'(ram[1][163]), 1);
    chk("t1_disp_after", int'(disp_bank), 1);

    // Reset mid-build while bank 1 is displayed.
    model_build(); reset_stats(); tick();
    repeat (399) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_wr_en", int'(wr_en), 0);
    chk("mid_rst_disp", int'(disp_bank), 0);
    exp_q.delete();
    exp_disp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Food on the snake head: snake must overwrite it; also a full clear after the reset.
    fx[0] = 5; fy[0] = 5;
    apply(); model_build(); reset_stats(); tick(); wait_idle(2000);
    chk("t2_clears", clr_w, 768);
    chk("t2_busy_cycles", busy_cyc, 774);
    chk("t2_hist_len", hist.size(), 2);
    if (hist.size() == 2) begin
      chk("t2_hist_first", int'(hist[0]), 2);
      chk("t2_hist_second", int'(hist[1]), 1);
    end
    chk("t2_tile165", int'(ram[1][165]), 1);

    // Clamping: len=20 -> 16, num_foods=7 -> 4; no power-up.
    len_v = 20; nf_v = 7; puv = 0;
    for (int i = 0; i < 16; i++) begin sx[i] = i; sy[i] = 10; end
    for (int i = 0; i < 4; i++) begin fx[i] = 20 + i; fy[i] = 2; end
    apply(); model_build(); reset_stats(); tick(); wait_idle(2000);
    chk("t3_snake_writes", snake_w, 16);
    chk("t3_food_writes", food_w, 4);
    chk("t3_pu_writes", pu_w, 0);
    chk("t3_busy_cycles", busy_cyc, 790);
    chk("t3_tile335", int'(ram[0][335]), 1);

    // Off-grid segment (31,24) keeps its cycle; slow power-up at (2,1).
    len_v = 3; sx[0] = 5; sy[0] = 5; sx[1] = 31; sy[1] = 24; sx[2] = 3; sy[2] = 5;
    nf_v = 1; fx[0] = 10; fy[0] = 7;
    puv = 1; puf = 0; pux = 2; puy = 1;
    apply(); model_build(); reset_stats(); tick(); wait_idle(2000);
    chk("t4_snake_writes", snake_w, 2);
    chk("t4_busy_cycles", busy_cyc, 774);
    chk("t4_pu_writes", pu_w, 1);
    chk("t4_tile34", int'(ram[1][34]), 3);

    // Ticks during a build: one queued rebuild, the next tick is lost.
    chk("t5_overrun_before", int'(overrun), 0);
    model_build(); model_build(); reset_stats();
    tick();
    repeat (99) @(posedge clk);
    tick();
    repeat (99) @(posedge clk);
    tick();
    wait_idle(4000);
    chk("t5_overrun", int'(overrun), 1);
    chk("t5_done_pulses", done_cnt, 2);
    chk("t5_busy_cycles", busy_cyc, 1548);
    chk("t5_idle_gap", gap_max, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_overrun_sticky", int'(overrun), 1);
    chk("t5_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
